// File: rtl/pipe_stage_reg.sv
// Generic pipeline-stage register: valid/ready handshake, optional 2-entry skid buffer,
// flush deferred while stalled, and a saturating count of cycles the head was blocked.
module pipe_stage_reg #(
    parameter int DATA_W  = 128,
    parameter int EXC_W   = 32,
    parameter int SKID    = 1,
    parameter int CLK_NEG = 1,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [31:0]       in_pc,
    input  logic [EXC_W-1:0]  in_exc,
    input  logic              in_delayslot,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [31:0]       out_pc,
    output logic [EXC_W-1:0]  out_exc,
    output logic              out_delayslot,
    output logic              out_nop,
    output logic              flush_pending,
    output logic [CNT_W-1:0]  stall_cnt
);
    localparam bit               L_SKID    = (SKID != 32'sd0);
    localparam bit               L_NEG     = (CLK_NEG != 32'sd0);
    localparam logic [CNT_W-1:0] L_CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_clk;
    logic              w_valid;
    logic              w_accept;
    logic              w_consume;
    logic              w_flush_apply;
    logic              w_load_main_in;
    logic              w_load_main_skid;
    logic              w_load_skid;
    logic              w_cnt_inc;
    logic              r_rdy;
    logic              r_flush_pending;
    logic [DATA_W-1:0] r_data;
    logic [31:0]       r_pc;
    logic [EXC_W-1:0]  r_exc;
    logic              r_ds;
    logic [DATA_W-1:0] r_sk_data;
    logic [31:0]       r_sk_pc;
    logic [EXC_W-1:0]  r_sk_exc;
    logic              r_sk_ds;
    logic [CNT_W-1:0]  r_cnt;

    generate
        if (L_NEG) begin : g_clk_neg
            assign w_clk = ~clk;
        end else begin : g_clk_pos
            assign w_clk = clk;
        end
    endgenerate

    assign w_valid       = (r_state != ST_EMPTY);
    assign w_consume     = w_valid & out_ready & ~stall;
    // Without a skid entry the head can be replaced on the edge it leaves; r_rdy acts as "out of reset".
    assign in_ready      = L_SKID ? r_rdy : (r_rdy & (~w_valid | w_consume));
    assign w_accept      = in_valid & in_ready;
    assign w_flush_apply = (flush | r_flush_pending) & ~stall;
    assign w_cnt_inc     = w_valid & ~w_consume & (r_cnt != L_CNT_MAX);

    // Next-state and datapath load selection
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (w_flush_apply) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt    = ST_ONE;
                        w_load_main_in = 1'b1;
                    end else begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (w_consume && w_accept) begin
                        w_load_main_in = 1'b1;
                    end else if (w_consume) begin
                        w_state_nxt = ST_EMPTY;
                    end else if (w_accept && L_SKID) begin
                        w_state_nxt = ST_FULL;
                        w_load_skid = 1'b1;
                    end else begin
                        w_state_nxt = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (w_consume) begin
                        w_state_nxt      = ST_ONE;
                        w_load_main_skid = 1'b1;
                    end else begin
                        w_state_nxt = ST_FULL;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    // Occupancy state, registered ready and deferred-flush flag
    always_ff @(posedge w_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= ST_EMPTY;
            r_rdy           <= 1'b0;
            r_flush_pending <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_rdy           <= L_SKID ? (w_state_nxt != ST_FULL) : 1'b1;
            r_flush_pending <= stall & (flush | r_flush_pending);
        end
    end

    // Head and skid entry payload registers
    always_ff @(posedge w_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data    <= {DATA_W{1'b0}};
            r_pc      <= 32'h0;
            r_exc     <= {EXC_W{1'b0}};
            r_ds      <= 1'b0;
            r_sk_data <= {DATA_W{1'b0}};
            r_sk_pc   <= 32'h0;
            r_sk_exc  <= {EXC_W{1'b0}};
            r_sk_ds   <= 1'b0;
        end else if (w_flush_apply) begin
            r_data    <= {DATA_W{1'b0}};
            r_pc      <= 32'h0;
            r_exc     <= {EXC_W{1'b0}};
            r_ds      <= 1'b0;
            r_sk_data <= {DATA_W{1'b0}};
            r_sk_pc   <= 32'h0;
            r_sk_exc  <= {EXC_W{1'b0}};
            r_sk_ds   <= 1'b0;
        end else begin
            if (w_load_main_in) begin
                r_data <= in_data;
                r_pc   <= in_pc;
                r_exc  <= in_exc;
                r_ds   <= in_delayslot;
            end else if (w_load_main_skid) begin
                r_data <= r_sk_data;
                r_pc   <= r_sk_pc;
                r_exc  <= r_sk_exc;
                r_ds   <= r_sk_ds;
            end
            if (w_load_skid) begin
                r_sk_data <= in_data;
                r_sk_pc   <= in_pc;
                r_sk_exc  <= in_exc;
                r_sk_ds   <= in_delayslot;
            end
        end
    end

    // Saturating blocked-head counter; survives flush, cleared only by reset
    always_ff @(posedge w_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (w_cnt_inc) begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign out_valid     = w_valid;
    assign out_nop       = ~w_valid;
    assign out_data      = r_data;
    assign out_pc        = r_pc;
    assign out_exc       = r_exc;
    assign out_delayslot = r_ds;
    assign flush_pending = r_flush_pending;
    assign stall_cnt     = r_cnt;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid/negedge instance and a no-skid/posedge instance,
// each compared against a queue scoreboard of accepted entries.
`timescale 1ns/1ps
module tb_pipe_stage_reg;
    localparam int DW = 128;
    localparam int EW = 32;
    localparam int CW = 16;

    typedef struct {
        logic [31:0]   pc;
        logic [DW-1:0] data;
        logic [EW-1:0] exc;
        logic          ds;
    } ent_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic          iv1 = 1'b0, ir1, ids1 = 1'b0, st1 = 1'b0, fl1 = 1'b0, ov1, or1 = 1'b0, ods1, nop1, fp1;
    logic [DW-1:0] id1 = '0, od1;
    logic [31:0]   ipc1 = 32'h0, opc1;
    logic [EW-1:0] iexc1 = '0, oexc1;
    logic [CW-1:0] cnt1;

    logic          iv0 = 1'b0, ir0, ids0 = 1'b0, st0 = 1'b0, fl0 = 1'b0, ov0, or0 = 1'b0, ods0, nop0, fp0;
    logic [DW-1:0] id0 = '0, od0;
    logic [31:0]   ipc0 = 32'h0, opc0;
    logic [EW-1:0] iexc0 = '0, oexc0;
    logic [CW-1:0] cnt0;

    int total = 0;
    int bad = 0;
    ent_t sb1[$];
    ent_t sb0[$];
    logic m_rdy1 = 1'b0;
    logic m_pend1 = 1'b0;
    logic [CW-1:0] m_cnt1 = '0;
    logic [CW-1:0] m_cnt0 = '0;

    pipe_stage_reg #(.DATA_W(DW), .EXC_W(EW), .SKID(1), .CLK_NEG(1), .CNT_W(CW)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
        .in_pc(ipc1), .in_exc(iexc1), .in_delayslot(ids1), .stall(st1), .flush(fl1),
        .out_valid(ov1), .out_ready(or1), .out_data(od1), .out_pc(opc1), .out_exc(oexc1),
        .out_delayslot(ods1), .out_nop(nop1), .flush_pending(fp1), .stall_cnt(cnt1)
    );

    pipe_stage_reg #(.DATA_W(DW), .EXC_W(EW), .SKID(0), .CLK_NEG(0), .CNT_W(CW)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv0), .in_ready(ir0), .in_data(id0),
        .in_pc(ipc0), .in_exc(iexc0), .in_delayslot(ids0), .stall(st0), .flush(fl0),
        .out_valid(ov0), .out_ready(or0), .out_data(od0), .out_pc(opc0), .out_exc(oexc0),
        .out_delayslot(ods0), .out_nop(nop0), .flush_pending(fp0), .stall_cnt(cnt0)
    );

    function automatic ent_t mk(input logic [31:0] pc);
        ent_t e;
        e.pc   = pc;
        e.data = {pc, ~pc, pc + 32'h1, pc ^ 32'hA5A5_5A5A};
        e.exc  = {pc[15:0], ~pc[15:0]};
        e.ds   = pc[2];
        return e;
    endfunction

    task automatic drive1(input logic v, input logic [31:0] pc, input logic s, input logic f, input logic r);
        ent_t e;
        e = mk(pc);
        iv1 = v; ipc1 = pc; id1 = e.data; iexc1 = e.exc; ids1 = e.ds;
        st1 = s; fl1 = f; or1 = r;
    endtask

    // Advance the falling-edge instance one edge while updating its reference model.
    task automatic edge1();
        logic acc, cons, fa;
        ent_t e;
        acc  = iv1 & m_rdy1;
        cons = (sb1.size() > 0) & or1 & ~st1;
        fa   = (fl1 | m_pend1) & ~st1;
        if (sb1.size() > 0 && !cons && m_cnt1 != 16'hFFFF) m_cnt1 = m_cnt1 + 16'd1;
        m_pend1 = st1 & (fl1 | m_pend1);
        if (fa) begin
            sb1.delete();
        end else begin
            if (cons) void'(sb1.pop_front());
            if (acc) begin
                e.pc = ipc1; e.data = id1; e.exc = iexc1; e.ds = ids1;
                sb1.push_back(e);
            end
        end
        m_rdy1 = (sb1.size() < 2);
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        total++; if (ov1 !== 1'b0 || nop1 !== 1'b1) begin bad++; $display("FAIL rst_valid got v=%b nop=%b exp v=0 nop=1", ov1, nop1); end
        total++; if (opc1 !== 32'h0 || od1 !== '0 || oexc1 !== '0 || ods1 !== 1'b0) begin bad++; $display("FAIL rst_fields got pc=%h exc=%h ds=%b exp 0", opc1, oexc1, ods1); end
        total++; if (fp1 !== 1'b0 || cnt1 !== 16'h0) begin bad++; $display("FAIL rst_flags got fp=%b cnt=%0d exp 0", fp1, cnt1); end
        total++; if (ir1 !== 1'b0 || ir0 !== 1'b0 || ov0 !== 1'b0) begin bad++; $display("FAIL rst_ready got ir1=%b ir0=%b ov0=%b exp 0", ir1, ir0, ov0); end
        reset_n = 1'b1;
        edge1();
        total++; if (ir1 !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b exp=1", ir1); end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 5; i++) begin
            drive1(i < 3, 32'h100 + 32'(4 * i), 1'b0, 1'b0, 1'b1);
            total++; if (ir1 !== 1'b1) begin bad++; $display("FAIL stream_ready cyc=%0d got=%b exp=1", i, ir1); end
            total++; if (ov1 !== (sb1.size() > 0)) begin bad++; $display("FAIL stream_valid cyc=%0d got=%b exp=%b", i, ov1, sb1.size() > 0); end
            if (sb1.size() > 0) begin
                total++;
                if (opc1 !== sb1[0].pc || od1 !== sb1[0].data || oexc1 !== sb1[0].exc || ods1 !== sb1[0].ds) begin
                    bad++; $display("FAIL stream_head cyc=%0d got pc=%h exp pc=%h", i, opc1, sb1[0].pc);
                end
            end
            edge1();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] pcs [3];
        logic [31:0] p;
        int idx;
        pcs[0] = 32'h200; pcs[1] = 32'h204; pcs[2] = 32'h208;
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            p = (idx < 3) ? pcs[idx] : 32'h0;
            drive1(idx < 3, p, 1'b0, 1'b0, c >= 3);
            total++; if (ir1 !== m_rdy1) begin bad++; $display("FAIL bp_ready cyc=%0d got=%b exp=%b", c, ir1, m_rdy1); end
            if (c == 2) begin
                total++; if (ir1 !== 1'b0) begin bad++; $display("FAIL bp_full cyc=%0d got=%b exp=0", c, ir1); end
            end
            total++; if (ov1 !== (sb1.size() > 0)) begin bad++; $display("FAIL bp_valid cyc=%0d got=%b exp=%b", c, ov1, sb1.size() > 0); end
            if (sb1.size() > 0) begin
                total++;
                if (opc1 !== sb1[0].pc || od1 !== sb1[0].data || oexc1 !== sb1[0].exc) begin
                    bad++; $display("FAIL bp_head cyc=%0d got pc=%h exp pc=%h", c, opc1, sb1[0].pc);
                end
            end
            if (iv1 && m_rdy1) idx++;
            edge1();
        end
        total++; if (idx !== 3 || ov1 !== 1'b0) begin bad++; $display("FAIL bp_drain got accepted=%0d v=%b exp 3 v=0", idx, ov1); end
    endtask

    task automatic test_flush_stall();
        drive1(1'b1, 32'h400, 1'b0, 1'b0, 1'b0);
        iexc1 = 32'h0000_0020;
        edge1();
        drive1(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        total++; if (ov1 !== 1'b1 || oexc1 !== 32'h20) begin bad++; $display("FAIL fs_head got v=%b exc=%h exp v=1 exc=20", ov1, oexc1); end
        edge1();
        drive1(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        total++; if (fp1 !== 1'b1) begin bad++; $display("FAIL fs_pending got=%b exp=1", fp1); end
        total++; if (ov1 !== 1'b1 || opc1 !== 32'h400 || oexc1 !== 32'h20) begin bad++; $display("FAIL fs_hold got v=%b pc=%h exc=%h exp 1/400/20", ov1, opc1, oexc1); end
        edge1();
        drive1(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        total++; if (fp1 !== 1'b1 || opc1 !== 32'h400) begin bad++; $display("FAIL fs_still got fp=%b pc=%h exp 1/400", fp1, opc1); end
        edge1();
        total++; if (ov1 !== 1'b0 || nop1 !== 1'b1 || fp1 !== 1'b0) begin bad++; $display("FAIL fs_applied got v=%b nop=%b fp=%b exp 0/1/0", ov1, nop1, fp1); end
        total++; if (oexc1 !== 32'h0 || opc1 !== 32'h0 || od1 !== '0) begin bad++; $display("FAIL fs_cleared got pc=%h exc=%h exp 0", opc1, oexc1); end
        drive1(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        edge1();
        drive1(1'b1, 32'h500, 1'b1, 1'b0, 1'b0);
        total++; if (fp1 !== m_pend1) begin bad++; $display("FAIL fs_pend2 got=%b exp=%b", fp1, m_pend1); end
        edge1();
        drive1(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        total++; if (ov1 !== 1'b1 || sb1.size() != 1 || opc1 !== sb1[0].pc) begin bad++; $display("FAIL fs_accept_pending got v=%b pc=%h exp v=1 pc=500", ov1, opc1); end
        edge1();
        total++; if (ov1 !== 1'b0 || fp1 !== 1'b0) begin bad++; $display("FAIL fs_discard_pending got v=%b fp=%b exp 0/0", ov1, fp1); end
        total++; if (cnt1 !== m_cnt1) begin bad++; $display("FAIL fs_cnt got=%0d exp=%0d", cnt1, m_cnt1); end
    endtask

    task automatic test_flush_accept();
        drive1(1'b1, 32'h300, 1'b0, 1'b1, 1'b1);
        total++; if (ir1 !== 1'b1) begin bad++; $display("FAIL fa_ready got=%b exp=1", ir1); end
        edge1();
        drive1(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        total++; if (ov1 !== 1'b0 || nop1 !== 1'b1 || opc1 !== 32'h0) begin bad++; $display("FAIL fa_discard got v=%b pc=%h exp v=0 pc=0", ov1, opc1); end
    endtask

    task automatic test_stall_sat();
        drive1(1'b1, 32'h600, 1'b0, 1'b0, 1'b0);
        edge1();
        drive1(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 65540; i++) begin
            if (i == 1000) begin
                total++; if (cnt1 !== m_cnt1 || opc1 !== 32'h600) begin bad++; $display("FAIL sat_mid got cnt=%0d pc=%h exp cnt=%0d pc=600", cnt1, opc1, m_cnt1); end
            end
            edge1();
        end
        total++; if (cnt1 !== 16'hFFFF || m_cnt1 !== 16'hFFFF) begin bad++; $display("FAIL sat_cnt got=%0d exp=65535", cnt1); end
        total++; if (ov1 !== 1'b1 || opc1 !== 32'h600) begin bad++; $display("FAIL sat_hold got v=%b pc=%h exp 1/600", ov1, opc1); end
        reset_n = 1'b0;
        #1;
        total++; if (ov1 !== 1'b0 || nop1 !== 1'b1 || opc1 !== 32'h0 || od1 !== '0 || oexc1 !== '0) begin bad++; $display("FAIL async_rst_head got v=%b nop=%b pc=%h exp 0/1/0", ov1, nop1, opc1); end
        total++; if (cnt1 !== 16'h0 || fp1 !== 1'b0 || ir1 !== 1'b0) begin bad++; $display("FAIL async_rst_flags got cnt=%0d fp=%b ir=%b exp 0", cnt1, fp1, ir1); end
        sb1.delete(); m_pend1 = 1'b0; m_cnt1 = '0; m_rdy1 = 1'b0;
        drive1(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        edge1();
        total++; if (ir1 !== 1'b1 || ov1 !== 1'b0) begin bad++; $display("FAIL rst2_release got ir=%b v=%b exp 1/0", ir1, ov1); end
    endtask

    task automatic test_noskid();
        int nxt, emitted;
        logic exp_cons, exp_rdy;
        ent_t e;
        nxt = 0; emitted = 0;
        @(negedge clk);
        #1;
        for (int c = 0; c < 100 && emitted < 20; c++) begin
            or0 = (c % 2 == 0);
            st0 = (c % 7 == 6);
            e = mk(32'h800 + 32'(4 * nxt));
            iv0 = (nxt < 20); ipc0 = e.pc; id0 = e.data; iexc0 = e.exc; ids0 = e.ds;
            #1;
            exp_cons = (sb0.size() > 0) & or0 & ~st0;
            exp_rdy  = (sb0.size() == 0) | exp_cons;
            total++; if (ir0 !== exp_rdy) begin bad++; $display("FAIL ns_ready cyc=%0d got=%b exp=%b", c, ir0, exp_rdy); end
            total++; if (ov0 !== (sb0.size() > 0) || nop0 !== (sb0.size() == 0)) begin bad++; $display("FAIL ns_valid cyc=%0d got=%b exp=%b", c, ov0, sb0.size() > 0); end
            if (sb0.size() > 0 && ov0 && !exp_cons && m_cnt0 != 16'hFFFF) m_cnt0 = m_cnt0 + 16'd1;
            if (exp_cons) begin
                total++;
                if (opc0 !== sb0[0].pc || od0 !== sb0[0].data || oexc0 !== sb0[0].exc || ods0 !== sb0[0].ds) begin
                    bad++; $display("FAIL ns_order cyc=%0d got pc=%h exp pc=%h", c, opc0, sb0[0].pc);
                end
                void'(sb0.pop_front());
                emitted++;
            end
            if (iv0 && exp_rdy) begin
                sb0.push_back(e);
                nxt++;
            end
            @(posedge clk);
            @(negedge clk);
            #1;
        end
        iv0 = 1'b0;
        total++; if (emitted !== 20 || nxt !== 20) begin bad++; $display("FAIL ns_count got emitted=%0d accepted=%0d exp 20/20", emitted, nxt); end
        total++; if (cnt0 !== m_cnt0 || fp0 !== 1'b0) begin bad++; $display("FAIL ns_cnt got=%0d exp=%0d", cnt0, m_cnt0); end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush_stall();
        test_flush_accept();
        test_stall_sat();
        test_noskid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline-stage register; generic successor of the fixed EX/MEM latch.
- Carries an opaque control/data bundle plus PC, exception vector and delay-slot flag.
- Adds valid/ready handshake, an optional 2-entry skid buffer, deferred flush under stall, and a saturating stall-cycle counter.
- Instantiated between any two stages: ID/EX, EX/MEM, MEM/WB.

Parameters:
- DATA_W, 128, width of opaque payload bundle.
- EXC_W, 32, width of exception-type vector.
- SKID, 1, 1 = 2-entry skid buffer (registered in_ready); 0 = single entry, combinational in_ready.
- CLK_NEG, 1, 1 = capture on falling clk edge; 0 = rising edge.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  stage clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept an entry this edge.
- in_data  in  DATA_W  payload.
- in_pc  in  32  instruction PC.
- in_exc  in  EXC_W  exception type from upstream.
- in_delayslot  in  1  instruction is in a branch delay slot.
- stall  in  1  hazard-unit hold; blocks downstream transfer.
- flush  in  1  discard all held entries.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts head.
- out_data  out  DATA_W  head payload.
- out_pc  out  32  head PC.
- out_exc  out  EXC_W  head exception type.
- out_delayslot  out  1  head delay-slot flag.
- out_nop  out  1  equals !out_valid; bubble marker.
- flush_pending  out  1  flush received under stall, not yet applied.
- stall_cnt  out  CNT_W  cycles head was blocked.

Behaviour:
- All state updates on the active edge selected by CLK_NEG. Reset acts immediately regardless of edge choice.
- Reset (reset_n=0): out_valid=0, out_data=0, out_pc=0, out_exc=0, out_delayslot=0, out_nop=1, flush_pending=0, stall_cnt=0, skid entry empty. in_ready=0 while in reset, 1 on the first cycle after release.
- Transfer definitions:
  - accept = in_valid & in_ready.
  - consume = out_valid & out_ready & !stall.
- SKID=1 state machine, using main (head) and skid registers:
  - EMPTY: accept -> ONE (input to main).
  - ONE: consume & accept -> ONE (input to main). consume only -> EMPTY. accept only -> FULL (input to skid). Neither -> ONE.
  - FULL: in_ready=0. consume -> ONE (skid moves to main). Otherwise hold.
  - in_ready = !FULL, registered. Throughput 1 entry per cycle, latency 1 edge.
- SKID=0:
  - in_ready = !out_valid | consume (combinational).
  - Single entry; consume & accept replaces the head in the same edge.
- Flush:
  - If flush & !stall: both entries cleared (out_nop=1, out_exc=0, out_pc=0, out_data=0). Any input accepted on the same edge is discarded. flush_pending cleared.
  - If flush & stall: flush_pending<=1 and state held. On the first edge with stall=0, the flush is applied exactly as above, including entries accepted while pending.
- Priority: reset > applied flush > consume/accept.
- Exception and delay-slot fields travel with their entry, unmodified.
- stall_cnt increments by 1 on each edge where out_valid & !consume. Saturates at 2^CNT_W-1; no wrap. Not cleared by flush; cleared only by reset.
- Holding: while stall=1, the head outputs remain bit-stable.

Test Plan:
- SKID=1, out_ready=1, stall=0; inject pc=0x100,0x104,0x108 on consecutive cycles -> out_pc presents each value one edge later, in_ready stays 1, no gaps.
- SKID=1, out_ready=0; inject 0x200,0x204,0x208 -> first two accepted, in_ready=0 after second. Raise out_ready -> 0x200 then 0x204 emitted, in_ready=1 again, 0x208 then accepted.
- Head valid with exc=0x0000_0020, stall=1, flush=1 for 1 cycle -> flush_pending=1, outputs unchanged. Drop stall -> next edge out_valid=0, out_nop=1, out_exc=0, flush_pending=0.
- flush=1 and in_valid=1 (pc=0x300), stall=0, same cycle -> entry discarded, out_valid=0 after edge.
- out_valid=1, stall=1 held for 70000 cycles with CNT_W=16 -> stall_cnt saturates at 65535. Assert reset_n=0 mid-hold -> all outputs at reset values immediately, without waiting for a clock edge.
- SKID=0, continuous input with out_ready toggling 1/0 -> in_ready tracks !out_valid|consume combinationally; no entry lost or duplicated (scoreboard by pc).
